irq_controller: RTL and testbench
=================================

Name: irq_controller

Overview:
- Memory-mapped external-interrupt source controller. It is the driving end of the processor's EXT input.
- Gathers N interrupt lines, latches rising edges into pending bits, and masks them with an enable register.
- Raises EXT toward the core and manages the claim/complete handshake over the data-memory load/store interface.
- Sits beside data memory on the MEM-stage bus and responds only to its address window.

Parameters:
- NUM_SRC, 8, number of interrupt source lines (1..31).
- BASE_ADDR, 32'h0000_F000, base byte address of the 16-byte register window.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- irq_src  input  NUM_SRC  interrupt request lines, level in, edge-sensitive
- mem_read_en  input  1  MEM-stage load strobe
- mem_write_en  input  1  MEM-stage store strobe
- addr  input  32  MEM-stage byte address (alu_result_MEM)
- write_data  input  32  store data
- read_data  output  32  load response, valid the cycle after mem_read_en
- hit  output  1  registered; high the cycle read_data is valid for this block (read-mux select)
- EXT  output  1  interrupt request to processor

Behaviour:
- Decode: an access targets this block when addr[31:4]==BASE_ADDR[31:4] and addr[1:0]==0. Offset is addr[3:2]. Accesses outside the window are ignored and leave state unchanged. Only full-word accesses are supported; sub-word strobes are treated as word accesses.
- Register map:
  - 0x0 PENDING: read-only. Bits above NUM_SRC read 0.
  - 0x4 ENABLE: read/write. Unused high bits are written as 0.
  - 0x8 CLAIM: read-only, with a side effect.
  - 0xC COMPLETE: write-only. Reads return 0.
- Edge detect: prev register holds irq_src of the last cycle. pending[i] is set when irq_src[i] & ~prev[i]. Pending bits are independent of ENABLE.
- Eligible set: pending & enable. Winner is the lowest index in the eligible set. ID = index+1, so 0 means none.
- FSM states: IDLE, ASSERT, IN_SERVICE.
  - IDLE -> ASSERT when the eligible set is non-zero.
  - ASSERT -> IN_SERVICE on a CLAIM read.
  - IN_SERVICE -> IDLE on a COMPLETE write whose write_data[4:0] equals the claimed ID.
  - ASSERT -> IDLE if the eligible set becomes zero (e.g. software clears ENABLE) before a claim.
- EXT: registered, equal to (next_state==ASSERT). It rises 1 cycle after the pending bit is set and stays high until the claim.
- CLAIM read:
  - In ASSERT: returns the winner ID and clears that pending bit in the same cycle. The claimed ID is stored in claimed_id[4:0].
  - In any other state: returns 0 with no side effect.
- COMPLETE write with a mismatched ID, or outside IN_SERVICE: ignored.
- Nesting: none. In IN_SERVICE, new pending bits accumulate but EXT stays low.
- Simultaneous events:
  - A new edge on the claimed source in the claim cycle leaves its pending bit set (set wins over clear).
  - A simultaneous load and store strobe is illegal; the store takes priority.
- Read latency: read_data and hit are registered, 1 cycle after the strobe. read_data holds its last value when not hit.
- Reset: an in-progress service is abandoned.
  - pending=0, enable=0, prev=0, claimed_id=0, state=IDLE.
  - EXT=0, read_data=0, hit=0.
  - Synchronizer stages are cleared to 0 (see Optional Feature).

Optional Feature:
- Macro: IRQ_SYNC_EN.
- Defined: irq_src passes through a 2-flop synchronizer per line before edge detect. A source edge reaches EXT 3 cycles after the edge (2 sync + 1).
- Undefined: irq_src is assumed synchronous to clk and feeds edge detect directly. Edge-to-EXT latency is 1 cycle.
- Register map and handshake are identical in both builds.

Decomposition:
- Shared package irq_pkg holds:
  - typedef irq_state_t {IDLE, ASSERT, IN_SERVICE};
  - offset constants IRQ_OFF_PENDING=2'd0, IRQ_OFF_ENABLE=2'd1, IRQ_OFF_CLAIM=2'd2, IRQ_OFF_COMPLETE=2'd3;
  - IRQ_ID_W=5.
- One sub-module, irq_prio_enc: combinational lowest-index priority encoder, NUM_SRC in, ID out (0 = none). It is reused for the winner computation.

Test Plan:
- Reset, then write ENABLE=0x04, pulse irq_src[2] 0->1 -> PENDING reads 0x04; EXT=1 one cycle after pending (3 with IRQ_SYNC_EN).
- Pending 0x0A with ENABLE=0xFF -> CLAIM returns 2, EXT drops, PENDING reads 0x08. Write COMPLETE=2 -> EXT reasserts next cycle. CLAIM returns 4.
- In IN_SERVICE with claimed ID 3, write COMPLETE=5 -> ignored, state stays, EXT=0. Write COMPLETE=3 -> IDLE.
- ENABLE=0 with pending 0x01 -> EXT stays 0, CLAIM returns 0. Write ENABLE=0x01 -> EXT=1.
- Edge on irq_src[0] in the same cycle as the CLAIM of ID 1 -> CLAIM returns 1, PENDING bit 0 remains 1.
- Assert rst while in IN_SERVICE with PENDING=0xFF -> all registers 0, EXT=0, CLAIM returns 0 the cycle after reset releases.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared types and register-map constants for the external-interrupt controller.
// Purely declarative: no logic, no latency.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ASSERT     = 2'd1,
    IN_SERVICE = 2'd2
  } irq_state_t;

  localparam logic [1:0] IRQ_OFF_PENDING  = 2'd0;
  localparam logic [1:0] IRQ_OFF_ENABLE   = 2'd1;
  localparam logic [1:0] IRQ_OFF_CLAIM    = 2'd2;
  localparam logic [1:0] IRQ_OFF_COMPLETE = 2'd3;

  localparam int IRQ_ID_W = 5;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index priority encoder: id = index+1 of the lowest set request, 0 when none.
// Combinational, zero latency; no flow control.
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int NUM_SRC = 8
) (
  input  logic [NUM_SRC-1:0]  req,
  output logic [IRQ_ID_W-1:0] id
);

  // Scanning downwards lets the lowest set index overwrite the higher ones.
  always_comb begin
    id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) id = IRQ_ID_W'(i + 1);
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Memory-mapped edge-latching interrupt controller driving EXT, with claim/complete handshake.
// Loads answer one cycle after the strobe; no backpressure. IRQ_SYNC_EN adds a 2-flop input synchronizer.
module irq_controller
  import irq_pkg::*;
#(
  parameter int          NUM_SRC   = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_F000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               mem_read_en,
  input  logic               mem_write_en,
  input  logic [31:0]        addr,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               hit,
  output logic               EXT
);

  logic [NUM_SRC-1:0]  src;
  logic [NUM_SRC-1:0]  prev;
  logic [NUM_SRC-1:0]  rise;
  logic [NUM_SRC-1:0]  pending;
  logic [NUM_SRC-1:0]  pending_nxt;
  logic [NUM_SRC-1:0]  enable;
  logic [NUM_SRC-1:0]  eligible;
  logic [NUM_SRC-1:0]  clr_mask;
  logic [IRQ_ID_W-1:0] winner_id;
  logic [IRQ_ID_W-1:0] claimed_id;
  logic [1:0]          off;
  logic                sel;
  logic                wr;
  logic                rd;
  logic                claim_fire;
  logic                complete_ok;
  logic                ext_nxt;
  logic [31:0]         rd_mux;
  irq_state_t          state;
  irq_state_t          next_state;
  logic                unused_wdata;

  assign unused_wdata = ^write_data;

`ifdef IRQ_SYNC_EN
  logic [NUM_SRC-1:0] sync_q1;
  logic [NUM_SRC-1:0] sync_q2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= irq_src;
      sync_q2 <= sync_q1;
    end
  end

  assign src = sync_q2;
`else
  assign src = irq_src;
`endif

  // Address decode; a simultaneous load is dropped in favour of the store.
  assign sel = (addr[31:4] == BASE_ADDR[31:4]) && (addr[1:0] == 2'b00);
  assign off = addr[3:2];
  assign wr  = mem_write_en && sel;
  assign rd  = mem_read_en && !mem_write_en && sel;

  assign eligible = pending & enable;

  irq_prio_enc #(
    .NUM_SRC(NUM_SRC)
  ) u_prio (
    .req(eligible),
    .id (winner_id)
  );

  assign claim_fire  = rd && (off == IRQ_OFF_CLAIM) && (state == ASSERT);
  assign complete_ok = wr && (off == IRQ_OFF_COMPLETE) && (state == IN_SERVICE)
                       && (write_data[IRQ_ID_W-1:0] == claimed_id);

  always_comb begin
    clr_mask = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      clr_mask[i] = claim_fire && (winner_id == IRQ_ID_W'(i + 1));
    end
  end

  // A fresh edge on the claimed line survives the claim clear.
  assign rise        = src & ~prev;
  assign pending_nxt = (pending & ~clr_mask) | rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (|eligible) next_state = ASSERT;
      end
      ASSERT: begin
        if (claim_fire)      next_state = IN_SERVICE;
        else if (!(|eligible)) next_state = IDLE;
      end
      IN_SERVICE: begin
        if (complete_ok) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    ext_nxt = (next_state == ASSERT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev       <= '0;
      pending    <= '0;
      enable     <= '0;
      claimed_id <= '0;
      EXT        <= 1'b0;
    end else begin
      prev    <= src;
      pending <= pending_nxt;
      EXT     <= ext_nxt;
      if (wr && (off == IRQ_OFF_ENABLE)) enable <= write_data[NUM_SRC-1:0];
      if (claim_fire) claimed_id <= winner_id;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (off)
      IRQ_OFF_PENDING:  rd_mux = 32'(pending);
      IRQ_OFF_ENABLE:   rd_mux = 32'(enable);
      IRQ_OFF_CLAIM:    rd_mux = claim_fire ? 32'(winner_id) : 32'd0;
      IRQ_OFF_COMPLETE: rd_mux = 32'd0;
      default:          rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      read_data <= '0;
      hit       <= 1'b0;
    end else begin
      hit <= rd;
      if (rd) read_data <= rd_mux;
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: directed vector table, hand-built corner sequences, then
// randomized traffic compared cycle-by-cycle against a behavioural model.
module tb_irq_controller;

  localparam int          NUM_SRC = 8;
  localparam logic [31:0] BASE    = 32'h0000_F000;
`ifdef IRQ_SYNC_EN
  localparam int SYNC_DLY = 2;
`else
  localparam int SYNC_DLY = 0;
`endif

  localparam logic [1:0] O_PEND = 2'd0;
  localparam logic [1:0] O_EN   = 2'd1;
  localparam logic [1:0] O_CLM  = 2'd2;
  localparam logic [1:0] O_CMP  = 2'd3;

  logic               clk = 1'b0;
  logic               rst;
  logic [NUM_SRC-1:0] irq_src;
  logic               mem_read_en;
  logic               mem_write_en;
  logic [31:0]        addr;
  logic [31:0]        write_data;
  logic [31:0]        read_data;
  logic               hit;
  logic               ext;

  always #5 clk = ~clk;

  irq_controller #(
    .NUM_SRC  (NUM_SRC),
    .BASE_ADDR(BASE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .irq_src     (irq_src),
    .mem_read_en (mem_read_en),
    .mem_write_en(mem_write_en),
    .addr        (addr),
    .write_data  (write_data),
    .read_data   (read_data),
    .hit         (hit),
    .EXT         (ext)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // miss: 0 in window, 1 outside window, 2 misaligned inside window
  task automatic set_bus(input logic w, input logic r, input logic [1:0] o,
                         input logic [31:0] d, input int miss);
    mem_write_en = w;
    mem_read_en  = r;
    write_data   = d;
    case (miss)
      1:       addr = BASE + 32'h100 + 32'(o) * 4;
      2:       addr = BASE + 32'(o) * 4 + 32'd1;
      default: addr = BASE + 32'(o) * 4;
    endcase
  endtask

  task automatic idle_bus();
    mem_write_en = 1'b0;
    mem_read_en  = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] o, output logic [31:0] d);
    set_bus(1'b0, 1'b1, o, 32'd0, 0);
    cyc();
    idle_bus();
    d = read_data;
  endtask

  task automatic bus_write(input logic [1:0] o, input logic [31:0] d);
    set_bus(1'b1, 1'b0, o, d, 0);
    cyc();
    idle_bus();
  endtask

  typedef struct {
    logic        wr;
    logic        rd;
    logic [1:0]  off;
    logic [31:0] wdat;
    int          miss;
    logic [7:0]  src;
    logic        e_ext;
    logic        e_hit;
    logic        chk_rd;
    logic [31:0] e_rdat;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic w, input logic r, input logic [1:0] o,
                              input logic [31:0] d, input int miss, input logic [7:0] s,
                              input logic e_ext, input logic e_hit, input logic chk,
                              input logic [31:0] e_rd);
    vec_t v;
    v.wr = w; v.rd = r; v.off = o; v.wdat = d; v.miss = miss; v.src = s;
    v.e_ext = e_ext; v.e_hit = e_hit; v.chk_rd = chk; v.e_rdat = e_rd;
    return v;
  endfunction

  // Behavioural reference model state
  logic [7:0]  m_pend, m_en, m_prev, m_sh1, m_sh2;
  logic        m_svc, m_ext, m_hit;
  logic [4:0]  m_claimed;
  logic [31:0] m_rd;

  task automatic model_reset();
    m_pend = 0; m_en = 0; m_prev = 0; m_sh1 = 0; m_sh2 = 0;
    m_svc = 0; m_ext = 0; m_hit = 0; m_claimed = 0; m_rd = 0;
  endtask

  // Claims succeed only while EXT is up; EXT next cycle is "not servicing and something eligible now".
  task automatic model_step();
    logic [7:0] s_eff, rise, elig, clr;
    logic       in_win, r, w, claim, new_ext;
    int         o, win;
`ifdef IRQ_SYNC_EN
    s_eff = m_sh2;
`else
    s_eff = irq_src;
`endif
    in_win = (addr >= BASE) && (addr < BASE + 32'd16) && (addr % 4 == 0);
    w      = mem_write_en && in_win;
    r      = mem_read_en && !mem_write_en && in_win;
    o      = int'((addr - BASE) / 4);
    elig   = m_pend & m_en;
    win    = -1;
    for (int i = NUM_SRC - 1; i >= 0; i--) if (elig[i]) win = i;
    claim  = r && (o == 2) && m_ext;
    if (r) begin
      case (o)
        0:       m_rd = 32'(m_pend);
        1:       m_rd = 32'(m_en);
        2:       m_rd = claim ? 32'(win + 1) : 32'd0;
        default: m_rd = 32'd0;
      endcase
    end
    m_hit   = r;
    new_ext = !m_svc && !claim && (elig != 0);
    clr     = claim ? (8'd1 << win) : 8'd0;
    if (claim) begin
      m_svc     = 1'b1;
      m_claimed = 5'(win + 1);
    end else if (m_svc && w && (o == 3) && (write_data[4:0] == m_claimed)) begin
      m_svc = 1'b0;
    end
    rise   = s_eff & ~m_prev;
    m_pend = (m_pend & ~clr) | rise;
    if (w && (o == 1)) m_en = write_data[7:0];
    m_prev = s_eff;
    m_sh2  = m_sh1;
    m_sh1  = irq_src;
    m_ext  = new_ext;
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  prev_src;

    rst = 1'b1; irq_src = '0; mem_read_en = 0; mem_write_en = 0; addr = 0; write_data = 0;
    repeat (3) cyc();
    check("reset ext", 32'(ext), 32'd0);
    check("reset hit", 32'(hit), 32'd0);
    check("reset rdata", read_data, 32'd0);
    rst = 1'b0;

    //            wr rd off     wdat  miss src    ext hit chk rdat
    tbl.push_back(mk(1, 0, O_EN,  32'h04, 0, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, O_EN,  32'h00, 0, 8'h04, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, O_EN,  32'h00, 0, 8'h04, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, O_PEND,32'h00, 0, 8'h04, 1, 1, 1, 32'h04));
    tbl.push_back(mk(0, 1, O_CLM, 32'h00, 0, 8'h04, 0, 1, 1, 32'd3));
    tbl.push_back(mk(1, 0, O_CMP, 32'd3,  0, 8'h04, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, O_EN,  32'h00, 0, 8'h04, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, O_EN,  32'hFF, 0, 8'h04, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, O_EN,  32'h00, 0, 8'h0E, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, O_EN,  32'h00, 0, 8'h0E, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, O_CLM, 32'h00, 0, 8'h0E, 0, 1, 1, 32'd2));
    tbl.push_back(mk(0, 1, O_PEND,32'h00, 0, 8'h0E, 0, 1, 1, 32'h08));
    tbl.push_back(mk(1, 0, O_CMP, 32'd2,  0, 8'h0E, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, O_EN,  32'h00, 0, 8'h0E, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, O_CLM, 32'h00, 0, 8'h0E, 0, 1, 1, 32'd4));
    tbl.push_back(mk(0, 0, O_EN,  32'h00, 0, 8'h0F, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, O_CMP, 32'd5,  0, 8'h0F, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, O_EN,  32'h00, 0, 8'h0F, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, O_CLM, 32'h00, 0, 8'h0F, 0, 1, 1, 32'd0));
    tbl.push_back(mk(1, 0, O_CMP, 32'd4,  0, 8'h0F, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, O_EN,  32'h00, 0, 8'h0F, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, O_EN,  32'h00, 0, 8'h0F, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, O_CLM, 32'h00, 0, 8'h0F, 0, 1, 1, 32'd0));
    tbl.push_back(mk(0, 1, O_PEND,32'h00, 0, 8'h0F, 0, 1, 1, 32'h01));
    tbl.push_back(mk(1, 0, O_EN,  32'h01, 0, 8'h0F, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, O_EN,  32'h00, 0, 8'h0F, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, O_EN,  32'h00, 0, 8'h0F, 1, 1, 1, 32'h01));
    tbl.push_back(mk(0, 1, O_CMP, 32'h00, 0, 8'h0F, 1, 1, 1, 32'd0));
    tbl.push_back(mk(0, 1, O_CLM, 32'h00, 0, 8'h0F, 0, 1, 1, 32'd1));
    tbl.push_back(mk(1, 0, O_CMP, 32'd1,  0, 8'h0F, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, O_EN,  32'h00, 1, 8'h0F, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, O_EN,  32'h00, 0, 8'h0F, 0, 1, 1, 32'h01));
    tbl.push_back(mk(0, 1, O_EN,  32'h00, 2, 8'h0F, 0, 0, 1, 32'h01));
    tbl.push_back(mk(1, 1, O_EN,  32'h03, 0, 8'h0F, 0, 0, 1, 32'h01));
    tbl.push_back(mk(0, 1, O_EN,  32'h00, 0, 8'h0F, 0, 1, 1, 32'h03));

    prev_src = 8'h00;
    foreach (tbl[i]) begin
      irq_src = tbl[i].src;
      set_bus(tbl[i].wr, tbl[i].rd, tbl[i].off, tbl[i].wdat, tbl[i].miss);
      cyc();
      idle_bus();
      check($sformatf("vec%0d ext", i), 32'(ext), 32'(tbl[i].e_ext));
      check($sformatf("vec%0d hit", i), 32'(hit), 32'(tbl[i].e_hit));
      if (tbl[i].chk_rd) check($sformatf("vec%0d rdata", i), read_data, tbl[i].e_rdat);
      if (tbl[i].src != prev_src) repeat (SYNC_DLY) cyc();
      prev_src = tbl[i].src;
    end

    // New edge on the claimed source in the claim cycle: the pending bit survives.
    irq_src = 8'h00;
    repeat (SYNC_DLY + 2) cyc();
    irq_src = 8'h01;
    cyc();
    irq_src = 8'h00;
    repeat (SYNC_DLY + 2) cyc();
    check("edge setup ext", 32'(ext), 32'd1);
    irq_src = 8'h01;
    repeat (SYNC_DLY) cyc();
    bus_read(O_CLM, d);
    check("edge claim id", d, 32'd1);
    check("edge claim ext", 32'(ext), 32'd0);
    bus_read(O_PEND, d);
    check("edge pending kept", d, 32'h01);
    bus_write(O_CMP, 32'd1);
    cyc();
    check("edge reassert ext", 32'(ext), 32'd1);
    bus_read(O_CLM, d);
    check("edge second claim", d, 32'd1);
    bus_write(O_CMP, 32'd1);

    // Reset in the middle of a service with every line pending.
    bus_write(O_EN, 32'hFF);
    irq_src = 8'h00;
    repeat (SYNC_DLY + 2) cyc();
    irq_src = 8'hFF;
    repeat (SYNC_DLY + 2) cyc();
    check("full ext", 32'(ext), 32'd1);
    bus_read(O_CLM, d);
    check("full claim id", d, 32'd1);
    bus_read(O_PEND, d);
    check("full pending", d, 32'hFE);
    rst = 1'b1;
    irq_src = 8'h00;
    cyc();
    check("midrst ext", 32'(ext), 32'd0);
    check("midrst hit", 32'(hit), 32'd0);
    check("midrst rdata", read_data, 32'd0);
    rst = 1'b0;
    bus_read(O_CLM, d);
    check("postrst claim", d, 32'd0);
    check("postrst hit", 32'(hit), 32'd1);
    bus_read(O_PEND, d);
    check("postrst pending", d, 32'd0);
    bus_read(O_EN, d);
    check("postrst enable", d, 32'd0);
    check("postrst ext", 32'(ext), 32'd0);

    // Randomized traffic against the model.
    rst = 1'b1;
    irq_src = 8'h00;
    idle_bus();
    cyc();
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 800; c++) begin
      int op;
      irq_src = irq_src ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      op = $urandom_range(0, 11);
      idle_bus();
      write_data = $urandom;
      addr = BASE;
      case (op)
        3, 4:  set_bus(0, 1, O_CLM, $urandom, 0);
        5, 6:  set_bus(0, 1, 2'($urandom_range(0, 3)), $urandom, 0);
        7:     set_bus(1, 0, O_EN, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom, 0);
        8, 9:  set_bus(1, 0, O_CMP,
                       ($urandom_range(0, 1) == 1) ? 32'(m_claimed) : 32'($urandom_range(0, 9)), 0);
        10:    set_bus($urandom_range(0, 1) == 1, 1'b1, 2'($urandom_range(0, 3)), $urandom,
                       $urandom_range(1, 2));
        11:    set_bus(1, 1, 2'($urandom_range(0, 3)), $urandom, 0);
        default: ;
      endcase
      model_step();
      cyc();
      idle_bus();
      check($sformatf("rnd%0d ext", c), 32'(ext), 32'(m_ext));
      check($sformatf("rnd%0d hit", c), 32'(hit), 32'(m_hit));
      check($sformatf("rnd%0d rdata", c), read_data, m_rd);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
